// File: rtl/vector_frame_buffer_pkg.sv
// Shared vector word layout and constants for the double-buffered vector list store.
package vector_frame_buffer_pkg;

    localparam int VEC_Y_MSB    = 17;
    localparam int VEC_Y_LSB    = 10;
    localparam int VEC_X_MSB    = 9;
    localparam int VEC_X_LSB    = 2;
    localparam int VEC_LINE_BIT = 1;
    localparam int VEC_POS_BIT  = 0;

    localparam logic [17:0] VEC_BLANK_WORD = 18'h0;

    typedef struct packed {
        logic [VEC_Y_MSB-VEC_Y_LSB:0] y;
        logic [VEC_X_MSB-VEC_X_LSB:0] x;
        logic                         line;
        logic                         pos;
    } vector_word_t;

    function automatic vector_word_t vec_word(input logic [7:0] y, input logic [7:0] x,
                                              input logic line, input logic pos);
        vector_word_t w;
        w.y    = y;
        w.x    = x;
        w.line = line;
        w.pos  = pos;
        return w;
    endfunction

endpackage

// File: rtl/vector_frame_buffer_if.sv
// Writer / display handshake bundle for vector_frame_buffer.
interface vector_frame_buffer_if #(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 18
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATAWIDTH-1:0]    wr_data;
    logic                    wr_last;
    logic [ADDRESSWIDTH-1:0] rd_addr;
    logic [DATAWIDTH-1:0]    rd_data;
    logic                    frame_drawn;
    logic [ADDRESSWIDTH:0]   front_count;
    logic                    pending;
    logic                    swapped;
    logic                    overflow;

    modport master (
        output wr_valid, wr_data, wr_last, rd_addr, frame_drawn,
        input  wr_ready, rd_data, front_count, pending, swapped, overflow
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_addr, frame_drawn,
        output wr_ready, rd_data, front_count, pending, swapped, overflow
    );
endinterface

// File: rtl/vector_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module vector_dp_ram #(
    parameter int ADDRESSWIDTH = 9,
    parameter int DATAWIDTH    = 18
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [ADDRESSWIDTH-1:0] i_waddr,
    input  logic [DATAWIDTH-1:0]    i_wdata,
    input  logic [ADDRESSWIDTH-1:0] i_raddr,
    output logic [DATAWIDTH-1:0]    o_rdata
);
    logic [DATAWIDTH-1:0] r_mem [2**ADDRESSWIDTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/vector_frame_buffer.sv
// Double-buffered vector list store; a committed back frame becomes front only on frame_drawn.
module vector_frame_buffer
    import vector_frame_buffer_pkg::*;
#(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_frame_buffer_if.slave bus
);
    logic                    r_front_sel;
    logic [ADDRESSWIDTH-1:0] r_wr_ptr;
    logic [ADDRESSWIDTH:0]   r_back_count;
    logic [ADDRESSWIDTH:0]   r_front_count;
    logic                    r_pending;
    logic                    r_swapped;
    logic                    r_overflow;
    logic                    r_blank;

    logic                    w_accept;
    logic                    w_at_end;
    logic                    w_commit;
    logic                    w_swap;
    logic [ADDRESSWIDTH:0]   w_commit_count;
    logic [DATAWIDTH-1:0]    w_ram_q;

    assign w_accept       = bus.wr_valid && !r_pending;
    assign w_at_end       = &r_wr_ptr;
    assign w_commit       = w_accept && (bus.wr_last || w_at_end);
    assign w_swap         = bus.frame_drawn && (r_pending || w_commit);
    assign w_commit_count = {1'b0, r_wr_ptr} + (ADDRESSWIDTH+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_front_sel   <= 1'b0;
            r_wr_ptr      <= '0;
            r_back_count  <= '0;
            r_front_count <= '0;
            r_pending     <= 1'b0;
            r_swapped     <= 1'b0;
            r_overflow    <= 1'b0;
            r_blank       <= 1'b1;
        end else begin
            r_swapped  <= w_swap;
            r_overflow <= w_accept && !bus.wr_last && w_at_end;
            r_blank    <= ({1'b0, bus.rd_addr} >= r_front_count);
            if (w_accept) begin
                r_wr_ptr <= w_commit ? '0 : r_wr_ptr + ADDRESSWIDTH'(1);
            end
            // A commit on the frame_drawn cycle bypasses back_count straight to the front.
            if (w_swap) begin
                r_front_sel   <= ~r_front_sel;
                r_front_count <= r_pending ? r_back_count : w_commit_count;
                r_pending     <= 1'b0;
            end else if (w_commit) begin
                r_back_count <= w_commit_count;
                r_pending    <= 1'b1;
            end
        end
    end

    vector_dp_ram #(
        .ADDRESSWIDTH(ADDRESSWIDTH + 1),
        .DATAWIDTH   (DATAWIDTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_accept),
        .i_waddr({~r_front_sel, r_wr_ptr}),
        .i_wdata(bus.wr_data),
        .i_raddr({r_front_sel, bus.rd_addr}),
        .o_rdata(w_ram_q)
    );

    assign bus.wr_ready    = !r_pending;
    assign bus.rd_data     = r_blank ? DATAWIDTH'(VEC_BLANK_WORD) : w_ram_q;
    assign bus.front_count = r_front_count;
    assign bus.pending     = r_pending;
    assign bus.swapped     = r_swapped;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_vector_frame_buffer.sv
// Table-driven and scoreboard checks for vector_frame_buffer.
module tb_vector_frame_buffer;
    import vector_frame_buffer_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [17:0] exp;
    } rd_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [17:0] exp_q [$];
    logic        rd_issue = 1'b0;
    logic        rd_pend  = 1'b0;
    logic [17:0] sb_exp;
    rd_vec_t     vecs [4];
    int          ovf_seen;

    vector_frame_buffer_if #(.ADDRESSWIDTH(8), .DATAWIDTH(18)) bus ();

    vector_frame_buffer #(.ADDRESSWIDTH(8), .DATAWIDTH(18)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rd_pend <= rd_issue;

    always @(negedge clk) begin
        if (rd_pend && !rst) begin
            if (exp_q.size() == 0) begin
                chk("rd_sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(sb_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [17:0] e);
        bus.rd_addr = a;
        rd_issue    = 1'b1;
        exp_q.push_back(e);
        step();
        rd_issue = 1'b0;
    endtask

    task automatic run_vecs();
        for (int i = 0; i < 4; i++) rd(vecs[i].addr, vecs[i].exp);
        @(negedge clk);
        #1;
    endtask

    task automatic set_vecs(input logic [17:0] e0, input logic [17:0] e1,
                            input logic [17:0] e2, input logic [17:0] e3);
        for (int i = 0; i < 4; i++) vecs[i].addr = 8'(i);
        vecs[0].exp = e0;
        vecs[1].exp = e1;
        vecs[2].exp = e2;
        vecs[3].exp = e3;
    endtask

    task automatic wr(input logic [17:0] d, input logic last);
        chk("wr_ready_before_write", 32'(bus.wr_ready), 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_last  = last;
        step();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic draw();
        bus.frame_drawn = 1'b1;
        step();
        bus.frame_drawn = 1'b0;
    endtask

    function automatic logic [17:0] ovw(input int i);
        vector_word_t w;
        w = vec_word(8'(i), 8'(255 - i), i[0], i[1]);
        return w;
    endfunction

    logic [17:0] wa, wb, wc, wd, we, wg, wh, wl, wm;

    initial begin
        wa = vec_word(8'h10, 8'h20, 1'b1, 1'b0);
        wb = vec_word(8'h31, 8'h42, 1'b0, 1'b1);
        wc = vec_word(8'hA5, 8'h5A, 1'b1, 1'b1);
        wd = vec_word(8'h01, 8'hFE, 1'b1, 1'b0);
        we = vec_word(8'h7F, 8'h80, 1'b0, 1'b1);
        wg = vec_word(8'h33, 8'hCC, 1'b1, 1'b0);
        wh = vec_word(8'hC3, 8'h3C, 1'b0, 1'b1);
        wl = vec_word(8'h55, 8'hAA, 1'b1, 1'b1);
        wm = vec_word(8'h0F, 8'hF0, 1'b0, 1'b1);

        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
        bus.rd_addr = '0; bus.frame_drawn = 1'b0;

        repeat (3) step();
        rst = 1'b0;
        chk("reset_front_count", 32'(bus.front_count), 32'd0);
        chk("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("reset_pending", 32'(bus.pending), 32'd0);
        chk("reset_swapped", 32'(bus.swapped), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        set_vecs(18'h0, 18'h0, 18'h0, 18'h0);
        run_vecs();

        // Frame 1: A, B, C
        step();
        wr(wa, 1'b0); wr(wb, 1'b0); wr(wc, 1'b1);
        chk("f1_pending", 32'(bus.pending), 32'd1);
        chk("f1_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("f1_front_before", 32'(bus.front_count), 32'd0);
        draw();
        chk("f1_swapped", 32'(bus.swapped), 32'd1);
        chk("f1_front_count", 32'(bus.front_count), 32'd3);
        chk("f1_pending_clr", 32'(bus.pending), 32'd0);
        chk("f1_wr_ready_after", 32'(bus.wr_ready), 32'd1);
        step();
        chk("f1_swapped_pulse", 32'(bus.swapped), 32'd0);
        set_vecs(wa, wb, wc, 18'h0);
        run_vecs();

        // frame_drawn with nothing pending
        step();
        draw();
        chk("idle_draw_swapped", 32'(bus.swapped), 32'd0);
        chk("idle_draw_front", 32'(bus.front_count), 32'd3);
        run_vecs();

        // Frame 2 while frame 1 is displayed
        step();
        wr(wd, 1'b0); wr(we, 1'b1);
        chk("f2_pending", 32'(bus.pending), 32'd1);
        set_vecs(wa, wb, wc, 18'h0);
        run_vecs();
        step();
        draw();
        chk("f2_swapped", 32'(bus.swapped), 32'd1);
        chk("f2_front_count", 32'(bus.front_count), 32'd2);
        set_vecs(wd, we, 18'h0, 18'h0);
        run_vecs();

        // Commit coinciding with frame_drawn
        step();
        wr(wg, 1'b0);
        bus.wr_valid = 1'b1; bus.wr_data = wh; bus.wr_last = 1'b1; bus.frame_drawn = 1'b1;
        step();
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.frame_drawn = 1'b0;
        chk("co_swapped", 32'(bus.swapped), 32'd1);
        chk("co_pending", 32'(bus.pending), 32'd0);
        chk("co_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("co_front_count", 32'(bus.front_count), 32'd2);
        set_vecs(wg, wh, 18'h0, 18'h0);
        run_vecs();

        // Full frame without wr_last
        step();
        ovf_seen = 0;
        for (int i = 0; i < 255; i++) begin
            wr(ovw(i), 1'b0);
            if (bus.overflow) ovf_seen++;
        end
        chk("ovf_early", 32'(ovf_seen), 32'd0);
        wr(ovw(255), 1'b0);
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        chk("ovf_pending", 32'(bus.pending), 32'd1);
        step();
        chk("ovf_pulse_end", 32'(bus.overflow), 32'd0);
        draw();
        chk("ovf_front_count", 32'(bus.front_count), 32'd256);
        vecs[0].addr = 8'd0;   vecs[0].exp = ovw(0);
        vecs[1].addr = 8'd100; vecs[1].exp = ovw(100);
        vecs[2].addr = 8'd254; vecs[2].exp = ovw(254);
        vecs[3].addr = 8'd255; vecs[3].exp = ovw(255);
        run_vecs();

        // Asynchronous reset mid-write
        step();
        wr(wd, 1'b0); wr(we, 1'b0);
        rd(8'd5, ovw(5));
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_front_count", 32'(bus.front_count), 32'd0);
        chk("arst_pending", 32'(bus.pending), 32'd0);
        chk("arst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("arst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("arst_swapped", 32'(bus.swapped), 32'd0);
        chk("arst_overflow", 32'(bus.overflow), 32'd0);
        step();
        rst = 1'b0;
        set_vecs(18'h0, 18'h0, 18'h0, 18'h0);
        run_vecs();
        step();
        wr(wl, 1'b0); wr(wm, 1'b1);
        draw();
        chk("post_rst_front", 32'(bus.front_count), 32'd2);
        set_vecs(wl, wm, 18'h0, 18'h0);
        run_vecs();

        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
